// File: rtl/fetch_stage_pkg.sv
// Shared IF-stage pipeline types: IF/ID register layout and default fetch address.
package fetch_stage_pkg;

    localparam int unsigned PIPE_XLEN = 32;
    localparam logic [PIPE_XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] pc_plus4;
        logic [PIPE_XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: PC ownership, single-outstanding imem request, 1-entry stall buffer and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = PIPE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hazardFEEnable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_buf_pc;
    logic [XLEN-1:0] r_buf_instr;
    if_id_t          r_if_id;

    logic            w_accept;
    logic            w_deliver_rsp;
    logic            w_deliver_buf;
    logic            w_capture_buf;
    logic [XLEN-1:0] w_redirect_aligned;
    logic            w_unused_redirect_lsbs;

    assign w_redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;

    assign if_id_valid    = r_if_id.valid;
    assign if_id_pc       = r_if_id.pc;
    assign if_id_pc_plus4 = r_if_id.pc_plus4;
    assign if_id_instr    = r_if_id.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect overrides every other transition; it only decides whether a stale rsp is still owed.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_deliver_rsp = 1'b0;
        w_deliver_buf = 1'b0;
        w_capture_buf = 1'b0;
        if (redirect_valid) begin
            unique case (r_state)
                S_REQ:  w_state_nxt = imem_req_ready ? S_DROP : S_REQ;
                S_WAIT: w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                S_FULL: w_state_nxt = S_REQ;
                S_DROP: w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_deliver_rsp = hazardFEEnable;
                        w_capture_buf = !hazardFEEnable;
                        w_state_nxt   = hazardFEEnable ? S_REQ : S_FULL;
                    end
                end
                S_FULL: begin
                    if (hazardFEEnable) begin
                        w_deliver_buf = 1'b1;
                        w_state_nxt   = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_buf_pc    <= '0;
            r_buf_instr <= '0;
            r_if_id     <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc <= w_redirect_aligned;
            end else if (w_accept) begin
                r_pc     <= r_pc + XLEN'(4);
                r_req_pc <= r_pc;
            end

            if (redirect_valid || w_deliver_buf) begin
                r_buf_pc    <= '0;
                r_buf_instr <= '0;
            end else if (w_capture_buf) begin
                r_buf_pc    <= r_req_pc;
                r_buf_instr <= imem_rsp_data;
            end

            // Stalled IF/ID holds every field; an unstalled idle cycle only drops valid.
            if (redirect_valid) begin
                r_if_id.valid <= 1'b0;
            end else if (w_deliver_rsp) begin
                r_if_id <= '{valid: 1'b1, pc: r_req_pc, pc_plus4: r_req_pc + XLEN'(4),
                             instr: imem_rsp_data};
            end else if (w_deliver_buf) begin
                r_if_id <= '{valid: 1'b1, pc: r_buf_pc, pc_plus4: r_buf_pc + XLEN'(4),
                             instr: r_buf_instr};
            end else if (hazardFEEnable) begin
                r_if_id.valid <= 1'b0;
            end
        end
    end

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_state == S_WAIT || r_state == S_DROP));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default-reset instance and a wrap-around RESET_PC instance
// share one variable-latency instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hz;
    logic        redir;
    logic [31:0] redir_pc;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    logic        a_req_valid, a_if_valid;
    logic [31:0] a_req_addr, a_if_pc, a_if_pc4, a_if_instr;
    logic        b_req_valid, b_if_valid;
    logic [31:0] b_req_addr, b_if_pc, b_if_pc4, b_if_instr;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          mem_lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .hazardFEEnable(hz), .redirect_valid(redir), .redirect_pc(redir_pc),
        .imem_req_valid(a_req_valid), .imem_req_ready(req_ready), .imem_req_addr(a_req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .if_id_valid(a_if_valid), .if_id_pc(a_if_pc), .if_id_pc_plus4(a_if_pc4),
        .if_id_instr(a_if_instr)
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .hazardFEEnable(hz), .redirect_valid(redir), .redirect_pc(redir_pc),
        .imem_req_valid(b_req_valid), .imem_req_ready(req_ready), .imem_req_addr(b_req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .if_id_valid(b_if_valid), .if_id_pc(b_if_pc), .if_id_pc_plus4(b_if_pc4),
        .if_id_instr(b_if_instr)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory answers mem_lat cycles after acceptance; it shares rst with the fetch stage.
    always @(posedge clk) begin
        if (rst) begin
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= '0;
        end else if (a_req_valid && req_ready) begin
            mem_busy <= 1'b1;
            mem_cnt  <= mem_lat - 1;
            mem_addr <= a_req_addr;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else mem_cnt <= mem_cnt - 1;
        end
    end

    assign rsp_valid = mem_busy && (mem_cnt == 0);
    assign rsp_data  = rsp_valid ? instr_of(mem_addr) : 32'hXXXX_XXXX;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hz = 1'b1; redir = 1'b0; redir_pc = '0; req_ready = 1'b1; mem_lat = 1;
        step();
        step();                                   // E0: last reset edge
        rst = 1'b0;
        chk("rst_req_valid", 32'(a_req_valid), 32'd1);
        chk("rst_addr", a_req_addr, 32'h0);
        chk("rst_if_valid", 32'(a_if_valid), 32'd0);
        chk("rst_if_pc", a_if_pc, 32'h0);
        chk("rst_if_instr", a_if_instr, 32'h0);
        chk("wrap_rst_addr", b_req_addr, 32'hFFFF_FFFC);

        // 1. streaming, 1-cycle memory
        step();                                   // E1 accept 0
        chk("s1_req_low_in_wait", 32'(a_req_valid), 32'd0);
        step();                                   // E2 deliver 0
        chk("s1_if_valid0", 32'(a_if_valid), 32'd1);
        chk("s1_if_pc0", a_if_pc, 32'h0);
        chk("s1_if_pc4_0", a_if_pc4, 32'h4);
        chk("s1_if_instr0", a_if_instr, instr_of(32'h0));
        chk("s1_addr4", a_req_addr, 32'h4);
        chk("wrap_if_pc", b_if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc4", b_if_pc4, 32'h0);
        chk("wrap_addr0", b_req_addr, 32'h0);
        step();                                   // E3 accept 4, bubble
        chk("s1_bubble", 32'(a_if_valid), 32'd0);
        chk("s1_bubble_pc_held", a_if_pc, 32'h0);
        step();                                   // E4 deliver 4
        chk("s1_if_pc4", a_if_pc, 32'h4);
        chk("s1_addr8", a_req_addr, 32'h8);
        chk("wrap_if_pc_next", b_if_pc, 32'h0);

        // 2. stall across the rsp for 0x8
        hz = 1'b0;
        step();                                   // E5 accept 8
        step();                                   // E6 rsp into buffer
        chk("s2_no_req_full", 32'(a_req_valid), 32'd0);
        chk("s2_hold_pc", a_if_pc, 32'h4);
        chk("s2_hold_valid", 32'(a_if_valid), 32'd1);
        step();                                   // E7 still stalled
        chk("s2_no_req_full2", 32'(a_req_valid), 32'd0);
        hz = 1'b1;
        step();                                   // E8 release buffer
        chk("s2_rel_pc", a_if_pc, 32'h8);
        chk("s2_rel_valid", 32'(a_if_valid), 32'd1);
        chk("s2_rel_instr", a_if_instr, instr_of(32'h8));
        chk("s2_addr_c", a_req_addr, 32'hC);

        // 3. redirect while waiting on a slow response
        mem_lat = 3; hz = 1'b0;
        step();                                   // E9 accept 0xC
        chk("s3_pre_valid", 32'(a_if_valid), 32'd1);
        redir = 1'b1; redir_pc = 32'h0000_0103;
        step();                                   // E10 redirect -> drop
        redir = 1'b0; hz = 1'b1;
        chk("s3_redir_kill", 32'(a_if_valid), 32'd0);
        chk("s3_no_req_drop", 32'(a_req_valid), 32'd0);
        step();                                   // E11 still waiting for stale rsp
        chk("s3_no_req_drop2", 32'(a_req_valid), 32'd0);
        step();                                   // E12 stale rsp discarded
        chk("s3_stale_dropped", 32'(a_if_valid), 32'd0);
        chk("s3_req_valid", 32'(a_req_valid), 32'd1);
        chk("s3_addr_100", a_req_addr, 32'h100);
        mem_lat = 1;
        step();                                   // E13 accept 0x100
        step();                                   // E14 deliver 0x100
        chk("s3_if_pc", a_if_pc, 32'h100);
        chk("s3_if_pc4", a_if_pc4, 32'h104);
        chk("s3_if_instr", a_if_instr, instr_of(32'h100));

        // 4. redirect during stall with buffer full
        hz = 1'b0;
        step();                                   // E15 accept 0x104
        step();                                   // E16 rsp buffered
        chk("s4_full_no_req", 32'(a_req_valid), 32'd0);
        redir = 1'b1; redir_pc = 32'h0000_0200;
        step();                                   // E17 redirect from S_FULL
        redir = 1'b0;
        chk("s4_kill_valid", 32'(a_if_valid), 32'd0);
        chk("s4_req_valid", 32'(a_req_valid), 32'd1);
        chk("s4_addr_200", a_req_addr, 32'h200);
        hz = 1'b1;
        step();                                   // E18 accept 0x200; buffer must not appear
        chk("s4_buf_cleared", 32'(a_if_valid), 32'd0);
        chk("s4_pc_held", a_if_pc, 32'h100);
        step();                                   // E19 deliver 0x200
        chk("s4_if_pc", a_if_pc, 32'h200);

        // 5. request back-pressure
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("s5_hold_valid%0d", i), 32'(a_req_valid), 32'd1);
            chk($sformatf("s5_hold_addr%0d", i), a_req_addr, 32'h204);
        end
        req_ready = 1'b1;
        step();                                   // accept 0x204
        chk("s5_accepted", 32'(a_req_valid), 32'd0);
        step();                                   // deliver 0x204
        chk("s5_if_pc", a_if_pc, 32'h204);
        chk("s5_addr_208", a_req_addr, 32'h208);

        // 6. reset while a request is outstanding
        hz = 1'b0;
        step();                                   // accept 0x208, IF/ID held
        chk("s6_pre_valid", 32'(a_if_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; hz = 1'b1;
        chk("s6_rst_valid", 32'(a_if_valid), 32'd0);
        chk("s6_rst_req", 32'(a_req_valid), 32'd1);
        chk("s6_rst_addr", a_req_addr, 32'h0);
        chk("s6_wrap_rst_addr", b_req_addr, 32'hFFFF_FFFC);
        step();
        step();
        chk("s6_wrap_if_pc", b_if_pc, 32'hFFFF_FFFC);
        chk("s6_wrap_if_valid", 32'(b_if_valid), 32'd1);
        chk("s6_wrap_addr0", b_req_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
